// File: rtl/msix_irq_scheduler.sv
// Round-robin MSI-X interrupt scheduler: latches per-source requests, issues one
// one-hot irq pulse at a time, waits for sent/fail/timeout, re-queues failures, then holds off.
module msix_irq_pend_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic clr,
  input  logic requeue,
  output logic pend
);
  // Set beats clear, so a request arriving while its vector is in flight is kept.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend <= 1'b0;
    else        pend <= (pend & ~clr) | req | requeue;
endmodule

module msix_irq_scheduler #(
  parameter int C_NUM_IRQ_INPUTS = 4,
  parameter int C_HOLDOFF_CYCLES = 16,
  parameter int C_TIMEOUT_CYCLES = 1024,
  parameter int C_CNT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [C_NUM_IRQ_INPUTS-1:0] irq_req,
  input  logic [C_NUM_IRQ_INPUTS-1:0] irq_mask,
  input  logic [1:0]                  msix_enable,
  output logic [C_NUM_IRQ_INPUTS-1:0] irq_out,
  input  logic                        cfg_interrupt_msix_sent,
  input  logic                        cfg_interrupt_msix_fail,
  output logic [C_NUM_IRQ_INPUTS-1:0] pending,
  output logic                        busy,
  output logic [C_CNT_WIDTH-1:0]      fail_count,
  output logic                        timeout_flag
);
  localparam int N  = C_NUM_IRQ_INPUTS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_ACK, HOLDOFF} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        rr_ptr, g_idx, arb_idx;
  logic                 arb_hit;
  logic [C_CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [N-1:0]         elig, clr, requeue;
  logic                 fail_inc, set_tf, timeout;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_lane
      msix_irq_pend_cell u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (irq_req[i]),
        .clr     (clr[i]),
        .requeue (requeue[i]),
        .pend    (pending[i])
      );
    end
  endgenerate

  assign elig = pending & ~irq_mask & {N{|msix_enable}};
  assign busy = (state != IDLE);

  // First eligible source after rr_ptr, wrapping modulo N.
  always_comb begin
    int idx;
    idx     = 0;
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!arb_hit && elig[IW'(idx)]) begin
        arb_hit = 1'b1;
        arb_idx = IW'(idx);
      end
    end
  end

  assign timeout = !cfg_interrupt_msix_sent && !cfg_interrupt_msix_fail &&
                   (cnt == C_CNT_WIDTH'(C_TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr       = '0;
    requeue   = '0;
    irq_out   = '0;
    fail_inc  = 1'b0;
    set_tf    = 1'b0;
    case (state)
      IDLE: if (arb_hit) state_nxt = GRANT;
      GRANT: begin
        irq_out[g_idx] = 1'b1;
        clr[g_idx]     = 1'b1;
        cnt_nxt        = '0;
        state_nxt      = WAIT_ACK;
      end
      WAIT_ACK: begin
        cnt_nxt = cnt + 1'b1;
        // Simultaneous sent and fail is treated as a fail.
        if (cfg_interrupt_msix_fail || timeout) begin
          requeue[g_idx] = 1'b1;
          fail_inc       = 1'b1;
        end
        set_tf = timeout;
        if (cfg_interrupt_msix_sent || cfg_interrupt_msix_fail || timeout) begin
          cnt_nxt   = '0;
          state_nxt = (C_HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
        end
      end
      HOLDOFF: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == C_CNT_WIDTH'(C_HOLDOFF_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rr_ptr       <= IW'(N - 1);
      g_idx        <= '0;
      fail_count   <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && arb_hit) begin
        g_idx  <= arb_idx;
        rr_ptr <= arb_idx;
      end
      if (fail_inc && fail_count != '1) fail_count <= fail_count + 1'b1;
      if (set_tf) timeout_flag <= 1'b1;
    end
  end
endmodule

// File: tb/tb_msix_irq_scheduler.sv
// Bench for msix_irq_scheduler: vector table, directed corner sequences and random
// stimulus compared every cycle against a countdown-based behavioural model.
module tb_msix_irq_scheduler;
  localparam int N = 4;
  localparam int H = 16;
  localparam int T = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] irq_req = '0, irq_mask = '0, irq_out, pending;
  logic [1:0] msix_enable = '0;
  logic sent = 1'b0, fail = 1'b0, busy, timeout_flag;
  logic [15:0] fail_count;

  msix_irq_scheduler #(.C_NUM_IRQ_INPUTS(N), .C_HOLDOFF_CYCLES(H),
                       .C_TIMEOUT_CYCLES(T), .C_CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .irq_mask(irq_mask),
    .msix_enable(msix_enable), .irq_out(irq_out),
    .cfg_interrupt_msix_sent(sent), .cfg_interrupt_msix_fail(fail),
    .pending(pending), .busy(busy), .fail_count(fail_count),
    .timeout_flag(timeout_flag));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 granted, 2 awaiting response, 3 holdoff; m_left counts down.
  logic [N-1:0] m_pend;
  int m_phase, m_g, m_rr, m_left, m_fc;
  bit m_tf;

  task automatic model_reset();
    m_pend = '0; m_phase = 0; m_g = 0; m_rr = N - 1; m_left = 0; m_fc = 0; m_tf = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] clr = '0, rq = '0;
    bit found = 0, timed = 0;
    case (m_phase)
      0: if (msix_enable != 0)
           for (int j = 1; j <= N; j++) begin
             int idx = (m_rr + j) % N;
             if (!found && m_pend[idx] && !irq_mask[idx]) begin
               found = 1; m_g = idx; m_rr = idx; m_phase = 1;
             end
           end
      1: begin clr[m_g] = 1'b1; m_left = T; m_phase = 2; end
      2: begin
        if (!fail && !sent) begin m_left--; timed = (m_left == 0); end
        if (fail || timed) begin rq[m_g] = 1'b1; if (m_fc < 65535) m_fc++; end
        if (timed) m_tf = 1;
        if (fail || sent || timed) begin
          if (H == 0) m_phase = 0; else begin m_phase = 3; m_left = H; end
        end
      end
      default: begin m_left--; if (m_left == 0) m_phase = 0; end
    endcase
    m_pend = (m_pend & ~clr) | irq_req | rq;
  endtask

  task automatic tick();
    logic [25:0] exp_v, act_v;
    logic [N-1:0] eo;
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
    cyc++;
    eo = (m_phase == 1) ? N'(1 << m_g) : '0;
    exp_v = {eo, m_phase != 0, m_pend, 16'(m_fc), m_tf};
    act_v = {irq_out, busy, pending, fail_count, timeout_flag};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL model cyc=%0d actual=%h required=%h", cyc, act_v, exp_v);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; irq_req = '0; irq_mask = '0; msix_enable = '0; sent = 0; fail = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", irq_out, 0); chk("rst_busy", busy, 0); chk("rst_pend", pending, 0);
    chk("rst_fc", fail_count, 0); chk("rst_tf", timeout_flag, 0);
    rst_n = 1'b1;
  endtask

  // Per grant: 0 sent, 1 fail, 2 sent+fail, 3 no response; sent when the queue is empty.
  int resp_q[$];
  int order[$];
  task automatic serve(input int cycles);
    int r;
    order.delete();
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (irq_out != 0) begin
        order.push_back(int'(irq_out));
        r = (resp_q.size() != 0) ? resp_q.pop_front() : 0;
        if (r != 3) begin
          tick();
          sent = (r == 0 || r == 2); fail = (r >= 1);
          tick();
          sent = 0; fail = 0;
        end
      end
    end
  endtask

  typedef struct {
    logic [N-1:0] req, mask;
    logic [1:0]   en;
    logic         sent, fail;
    logic [N-1:0] exp_out;
    logic         exp_busy;
    logic [N-1:0] exp_pend;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic [N-1:0] rq, logic [N-1:0] mk_, logic s,
                              logic [N-1:0] eo, logic eb, logic [N-1:0] ep);
    vec_t v;
    v.req = rq; v.mask = mk_; v.en = 2'b01; v.sent = s; v.fail = 1'b0;
    v.exp_out = eo; v.exp_busy = eb; v.exp_pend = ep;
    return v;
  endfunction

  initial begin
    // single request, sent, then a 16-cycle holdoff
    for (int i = 0; i < 23; i++)
      tbl.push_back(mk((i == 0) ? 4'b0001 : 4'b0000, 4'b0000, (i == 6),
                       (i == 1) ? 4'b0001 : 4'b0000, (i >= 1 && i <= 21),
                       (i <= 1) ? 4'b0001 : 4'b0000));
    // masked request stays pending, grants once the mask is cleared
    tbl.push_back(mk(4'b0100, 4'b0100, 0, 4'b0000, 0, 4'b0100));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0000, 4'b0100, 0, 4'b0000, 0, 4'b0100));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 4'b0100, 1, 4'b0100));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 4'b0000, 1, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 1, 4'b0000, 1, 4'b0000));

    do_reset();
    foreach (tbl[i]) begin
      irq_req = tbl[i].req; irq_mask = tbl[i].mask; msix_enable = tbl[i].en;
      sent = tbl[i].sent; fail = tbl[i].fail;
      tick();
      chk($sformatf("tbl_out[%0d]", i), irq_out, tbl[i].exp_out);
      chk($sformatf("tbl_busy[%0d]", i), busy, tbl[i].exp_busy);
      chk($sformatf("tbl_pend[%0d]", i), pending, tbl[i].exp_pend);
    end
    irq_req = 0; irq_mask = 0; sent = 0;

    // all four sources at once: round-robin from rr_ptr=3
    do_reset();
    msix_enable = 2'b01; irq_req = 4'hF; tick(); irq_req = 0;
    serve(150);
    chk("rr_npulses", order.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order[%0d]", i), (i < order.size()) ? order[i] : 0, 1 << i);
    chk("rr_pend", pending, 0);

    // fail on vector 1 requeues it behind vector 2
    do_reset();
    msix_enable = 2'b01; irq_req = 4'b0110; tick(); irq_req = 0;
    tick(); chk("fail_grant", irq_out, 4'b0010);
    tick(); fail = 1; tick(); fail = 0;
    chk("fail_pend", pending, 4'b0110); chk("fail_fc", fail_count, 1); chk("fail_busy", busy, 1);
    serve(80);
    chk("fail_n", order.size(), 2);
    chk("fail_o0", (order.size() > 0) ? order[0] : 0, 4'b0100);
    chk("fail_o1", (order.size() > 1) ? order[1] : 0, 4'b0010);

    // timeout after T cycles of silence
    do_reset();
    msix_enable = 2'b01; irq_req = 4'b0001; tick(); irq_req = 0;
    tick(); chk("to_grant", irq_out, 1);
    repeat (T) tick();
    chk("to_tf_early", timeout_flag, 0); chk("to_pend_early", pending, 0); chk("to_busy", busy, 1);
    tick();
    chk("to_tf", timeout_flag, 1); chk("to_fc", fail_count, 1); chk("to_pend", pending, 1);

    // enable off blocks grants; sent&fail counts as fail; async reset mid-wait
    do_reset();
    irq_req = 4'b0011; tick(); irq_req = 0;
    for (int i = 0; i < 5; i++) begin tick(); chk("noen_out", irq_out, 0); end
    chk("noen_pend", pending, 4'b0011); chk("noen_busy", busy, 0);
    msix_enable = 2'b01; tick(); chk("en_grant", irq_out, 4'b0001);
    tick(); sent = 1; fail = 1; tick(); sent = 0; fail = 0;
    chk("both_fc", fail_count, 1); chk("both_pend", pending, 4'b0011); chk("both_tf", timeout_flag, 0);
    begin
      int c = 0;
      while (irq_out == 0 && c < 40) begin tick(); c++; end
      chk("regrant_seen", irq_out, 4'b0010);
    end
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", irq_out, 0); chk("arst_busy", busy, 0); chk("arst_pend", pending, 0);
    chk("arst_fc", fail_count, 0); chk("arst_tf", timeout_flag, 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      irq_req     = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 30) == 0) irq_mask = N'($urandom) & N'($urandom);
      msix_enable = ($urandom_range(0, 12) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      sent        = ($urandom_range(0, 5) == 0);
      fail        = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
